// File: rtl/nor_logic_unit.sv
// Pipelined bitwise NOR stage with valid qualifier, reduction flags and a
// saturating count of all-ones results.
module nor_logic_unit #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  output logic             O_all,
  output logic             O_any,
  output logic [15:0]      match_cnt
);

  logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
  logic [STAGES-1:0]            v_q, v_d;
  logic [15:0]                  match_cnt_q, match_cnt_d;
  logic                         load_match;

  // Stage 0 samples the operands; later stages only advance on a valid bubble-free slot.
  assign v_d[0]    = en;
  assign data_d[0] = en ? ~(I1 | I2) : data_q[0];

  for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
    assign v_d[gi]    = v_q[gi-1];
    assign data_d[gi] = v_q[gi-1] ? data_q[gi-1] : data_q[gi];
  end

  // Count the value that is about to land in the output stage.
  assign load_match = v_d[STAGES-1] && (&data_d[STAGES-1]);

  always_comb begin
    match_cnt_d = match_cnt_q;
    if (load_match && (match_cnt_q != 16'hFFFF)) begin
      match_cnt_d = match_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q      <= '0;
      v_q         <= '0;
      match_cnt_q <= '0;
    end else begin
      data_q      <= data_d;
      v_q         <= v_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign O         = data_q[STAGES-1];
  assign O_valid   = v_q[STAGES-1];
  assign O_all     = &data_q[STAGES-1];
  assign O_any     = |data_q[STAGES-1];
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_nor_logic_unit.sv
// Directed bench for nor_logic_unit across several WIDTH/STAGES configurations.
module tb_nor_logic_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // WIDTH=1, STAGES=1
  logic       en1;
  logic [0:0] a1, b1, o1;
  logic       v1, all1, any1;
  logic [15:0] cnt1;
  // WIDTH=8, STAGES=3
  logic       en8;
  logic [7:0] a8, b8, o8;
  logic       v8, all8, any8;
  logic [15:0] cnt8;
  // WIDTH=4, STAGES=2
  logic       en4;
  logic [3:0] a4, b4, o4;
  logic       v4, all4, any4;
  logic [15:0] cnt4;
  // WIDTH=4, STAGES=1 (saturation)
  logic       ens;
  logic [3:0] as, bs, os;
  logic       vs, alls, anys;
  logic [15:0] cnts;

  nor_logic_unit #(.WIDTH(1), .STAGES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .I1(a1), .I2(b1),
    .O(o1), .O_valid(v1), .O_all(all1), .O_any(any1), .match_cnt(cnt1));
  nor_logic_unit #(.WIDTH(8), .STAGES(3)) u_w8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .I1(a8), .I2(b8),
    .O(o8), .O_valid(v8), .O_all(all8), .O_any(any8), .match_cnt(cnt8));
  nor_logic_unit #(.WIDTH(4), .STAGES(2)) u_w4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .I1(a4), .I2(b4),
    .O(o4), .O_valid(v4), .O_all(all4), .O_any(any4), .match_cnt(cnt4));
  nor_logic_unit #(.WIDTH(4), .STAGES(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(ens), .I1(as), .I2(bs),
    .O(os), .O_valid(vs), .O_all(alls), .O_any(anys), .match_cnt(cnts));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Alternating-enable stimulus for the STAGES=2 instance, with hand-computed results.
  logic       alt_en  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0] alt_a   [7] = '{4'h1, 4'hF, 4'h0, 4'h0, 4'h8, 4'h3, 4'h0};
  logic [3:0] alt_b   [7] = '{4'h2, 4'hF, 4'h4, 4'h0, 4'h1, 4'h0, 4'h0};
  logic       alt_xv  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] alt_xo  [7] = '{4'h0, 4'hC, 4'hC, 4'hB, 4'hB, 4'h6, 4'h6};

  initial begin
    rst_n = 1'b0;
    en1 = 0; a1 = 0; b1 = 0;
    en8 = 0; a8 = 0; b8 = 0;
    en4 = 0; a4 = 0; b4 = 0;
    ens = 0; as = 0; bs = 0;
    tick();
    tick();
    check("rst_o",     o1,   0);
    check("rst_valid", v1,   0);
    check("rst_cnt",   cnt1, 0);
    check("rst_o8",    o8,   0);

    // WIDTH=1 truth table, one result per clock
    rst_n = 1'b1;
    en1 = 1; a1 = 0; b1 = 0; tick();
    check("tt00_o", o1, 1); check("tt00_v", v1, 1); check("tt00_cnt", cnt1, 1);
    a1 = 0; b1 = 1; tick();
    check("tt01_o", o1, 0); check("tt01_v", v1, 1);
    a1 = 1; b1 = 0; tick();
    check("tt10_o", o1, 0); check("tt10_v", v1, 1);
    a1 = 1; b1 = 1; tick();
    check("tt11_o", o1, 0); check("tt11_v", v1, 1); check("tt_cnt", cnt1, 1);
    check("tt11_any", any1, 0);

    // Reset mid-stream overrides en
    rst_n = 1'b0; a1 = 0; b1 = 0; tick();
    check("mrst_o", o1, 0); check("mrst_v", v1, 0); check("mrst_cnt", cnt1, 0);
    tick();
    check("mrst2_v", v1, 0);
    rst_n = 1'b1; tick();
    check("post_rst_o", o1, 1); check("post_rst_v", v1, 1); check("post_rst_all", all1, 1);
    check("post_rst_cnt", cnt1, 1);

    // WIDTH=8 STAGES=3 single pulse
    en1 = 0;
    en8 = 1; a8 = 8'h0F; b8 = 8'h30; tick();
    en8 = 0; a8 = 8'h00; b8 = 8'h00;
    check("p3_lat1_v", v8, 0);
    tick();
    check("p3_lat2_v", v8, 0);
    tick();
    check("p3_o", o8, 8'hC0); check("p3_v", v8, 1);
    check("p3_any", any8, 1); check("p3_all", all8, 0);
    tick();
    check("p3_hold_v", v8, 0); check("p3_hold_o", o8, 8'hC0);
    check("p3_cnt", cnt8, 0);

    // WIDTH=4 STAGES=2 alternating enable
    for (int i = 0; i < 7; i++) begin
      en4 = alt_en[i]; a4 = alt_a[i]; b4 = alt_b[i];
      tick();
      check($sformatf("alt%0d_v", i), v4, alt_xv[i]);
      check($sformatf("alt%0d_o", i), o4, alt_xo[i]);
    end
    check("alt_cnt", cnt4, 0);

    // Enable low with toggling operands after reset
    rst_n = 1'b0; en4 = 0; tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a1 = 1'(i); b1 = 1'(i >> 1); a4 = 4'(i * 3); b4 = 4'(i * 5);
      tick();
    end
    check("idle_o1", o1, 0); check("idle_v1", v1, 0); check("idle_cnt1", cnt1, 0);
    check("idle_o4", o4, 0); check("idle_v4", v4, 0); check("idle_cnt4", cnt4, 0);

    // Saturation of match_cnt
    ens = 1; as = 4'h0; bs = 4'h0;
    for (int i = 0; i < 65534; i++) tick();
    check("sat_pre", cnts, 16'hFFFE);
    tick();
    check("sat_hit", cnts, 16'hFFFF);
    for (int i = 0; i < 20; i++) tick();
    check("sat_hold", cnts, 16'hFFFF);
    check("sat_o", os, 4'hF); check("sat_all", alls, 1); check("sat_v", vs, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nor_logic_unit.md
Name: nor_logic_unit

Overview:
Registered, pipelined bitwise two-input NOR stage with a valid qualifier. It sits as a datapath primitive in the logic-gate block set. It computes O = ~(I1 | I2) per bit and delivers the result STAGES clocks later. It also produces reduction flags and a saturating count of all-ones results for test observability.

Parameters:
WIDTH, 1, bit width of I1, I2 and O (legal 1..64).
STAGES, 1, pipeline latency in clocks from input sample to O (legal 1..4).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset.
en  input  1  input valid; I1/I2 are sampled only when en=1.
I1  input  WIDTH  first operand.
I2  input  WIDTH  second operand.
O  output  WIDTH  registered result ~(I1|I2) of the last valid sample to exit the pipeline.
O_valid  output  1  high for exactly one clock per valid result arriving at O.
O_all  output  1  AND-reduction of O (every bit of O is 1, i.e. both operands were zero).
O_any  output  1  OR-reduction of O.
match_cnt  output  16  count of valid results with O_all=1; saturates at 16'hFFFF.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: on a rising clk edge with rst_n=0, the following are cleared to 0: all pipeline data and valid registers, O, O_valid, O_all, O_any and match_cnt. Reset overrides en.
- Stage 1 is computed on an edge with en=1: data1 <= ~(I1|I2) and v1 <= 1.
- Stage 1 on an edge with en=0: v1 <= 0 and data1 holds its value.
- Stage k (2..STAGES): if v(k-1)=1, then data_k <= data_(k-1) and v_k <= 1; otherwise v_k <= 0 and data_k holds.
- Outputs: O = data_STAGES, O_valid = v_STAGES.
- Latency: a sample taken at edge n appears on O with O_valid=1 after edge n+STAGES-1. STAGES=1 gives a result one clock after sampling.
- Hold: O keeps the last valid result while O_valid=0. It never shows bubble data.
- O_all and O_any are combinational functions of O, so they are valid whenever O is.
- match_cnt increments by 1 on any edge where the result being loaded into O is valid and all ones. It holds at 16'hFFFF once reached.
- Throughput: one result per clock with en held high; no backpressure.
- Reset mid-operation discards in-flight samples. The first post-reset O_valid comes STAGES clocks after the first en=1 sample.
- Only defined widths are used; there are no X-propagation requirements beyond normal RTL semantics.

Test Plan:
- WIDTH=1, STAGES=1, rst_n=1, en=1; drive (I1,I2) = 00,01,10,11 on consecutive clocks -> O = 1,0,0,0 one clock later with O_valid=1 each cycle; match_cnt ends at 1.
- Assert rst_n=0 for 2 clocks mid-stream -> O=0, O_valid=0, match_cnt=0 at the first reset edge. After release, with en=1 and I1=I2=0, O=1 one clock later.
- WIDTH=8, STAGES=3: drive I1=8'h0F, I2=8'h30 with a single en pulse -> O=8'hC0 and O_valid=1 exactly 3 clocks later for one cycle, O_any=1, O_all=0.
- Alternate en 1/0 with WIDTH=4, STAGES=2 and distinct inputs -> O_valid follows the en pattern delayed 2 clocks; O holds previous value on bubble cycles.
- WIDTH=4: drive I1=I2=4'h0 with en=1 continuously for 70000 clocks -> match_cnt saturates at 16'hFFFF and stays there; O=4'hF, O_all=1.
- en=0 with toggling I1/I2 after reset -> O stays 0, O_valid stays 0, match_cnt stays 0.
